alu_multicycle: RTL

ALU_MULTICYCLE -- requirements
Module: alu_multicycle

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_mul_iter.sv | 59 +++++
 rtl/alu_multicycle.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation encodings, FSM
// state encoding and the bit positions of the packed flag vector.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SLL  = 4'b0001,
    OP_SUB  = 4'b0010,
    OP_SLT  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SRL  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_AND  = 4'b0111,
    OP_SLTU = 4'b1000,
    OP_MUL  = 4'b1010,
    OP_SRA  = 4'b1101
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  // Bit positions inside the packed flag vector.
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_S = 2;
  localparam int FLAG_Z = 3;
  localparam int NFLAGS = 4;

  // A zero result is what reset presents, so only ZF is set.
  localparam logic [NFLAGS-1:0] FLAGS_RESET = 4'b1000;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-and-add multiplier, one multiplier bit per cycle.
// Bit 0 is folded in when the operands are captured on start, the remaining
// WIDTH-1 bits follow one per clock; done is high for exactly one cycle once
// all WIDTH bits have been consumed. Only the low WIDTH product bits are kept.
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic             r_run;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;

  // Capture operands on start, then add one shifted partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run    <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking would chain the shifts within one edge.
      r_run    <= 1'b1;
      r_cnt    <= CW'(1);
      r_mcand  <= {op_a[WIDTH-2:0], 1'b0};
      r_mplier <= {1'b0, op_b[WIDTH-1:1]};
      r_acc    <= op_b[0] ? op_a : '0;
    end else if (r_run) begin
      if (r_cnt == LAST) begin
        r_run <= 1'b0;
      end else begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
        r_cnt    <= r_cnt + CW'(1);
      end
    end
  end

  assign done    = r_run && (r_cnt == LAST);
  assign product = r_acc;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready handshakes on both sides. Single-cycle
// operations register their result on acceptance; MUL is handed to the
// iterative multiplier and the result is registered when it finishes.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             ZF,
  output logic             SF,
  output logic             CF,
  output logic             VF,
  output logic             Busy
);

  alu_state_e        r_state;
  alu_state_e        w_state_next;
  logic              r_out_valid;
  logic [WIDTH-1:0]  r_result;
  logic [NFLAGS-1:0] r_flags;

  logic              w_in_ready;
  logic              w_mul_start;
  logic              w_load_alu;
  logic              w_load_mul;
  logic              w_out_valid_next;
  logic              w_mul_done;
  logic [WIDTH-1:0]  w_mul_product;

  logic              w_is_sub;
  logic [WIDTH-1:0]  w_b_op;
  logic [WIDTH:0]    w_sum;
  logic [SHW-1:0]    w_shamt;
  logic [WIDTH-1:0]  w_alu_res;
  logic              w_alu_c;
  logic              w_alu_v;

  function automatic logic [NFLAGS-1:0] make_flags(input logic [WIDTH-1:0] res,
                                                   input logic c, input logic v);
    logic [NFLAGS-1:0] f;
    f         = '0;
    f[FLAG_Z] = (res == '0);
    f[FLAG_S] = res[WIDTH-1];
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  // SUB shares the adder as A + ~B + 1, so CF=1 means no borrow.
  assign w_is_sub = (ALUControl == OP_SUB);
  assign w_b_op   = w_is_sub ? ~SrcB : SrcB;
  assign w_sum    = {1'b0, SrcA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_is_sub};
  assign w_shamt  = SrcB[SHW-1:0];

  // Single-cycle datapath; carry and overflow are meaningful only for ADD/SUB.
  always_comb begin
    // NOTE: every output gets a default before the case so that no path
    // leaves a value unassigned, which would infer a latch.
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    case (ALUControl)
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum[WIDTH-1:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (SrcA[WIDTH-1] == w_b_op[WIDTH-1]) &&
                    (w_sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLL:  w_alu_res = SrcA << w_shamt;
      OP_SRL:  w_alu_res = SrcA >> w_shamt;
      OP_SRA:  w_alu_res = $signed(SrcA) >>> w_shamt;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_XOR:  w_alu_res = SrcA ^ SrcB;
      OP_OR:   w_alu_res = SrcA | SrcB;
      OP_AND:  w_alu_res = SrcA & SrcB;
      default: w_alu_res = '0;
    endcase
  end

  // Next-state and handshake decode: accept only when idle with a free output slot.
  always_comb begin
    w_state_next     = r_state;
    w_in_ready       = (r_state == ST_IDLE) && (!r_out_valid || OutReady);
    w_mul_start      = 1'b0;
    w_load_alu       = 1'b0;
    w_load_mul       = 1'b0;
    w_out_valid_next = r_out_valid && !OutReady;
    case (r_state)
      ST_IDLE: begin
        if (InValid && w_in_ready) begin
          if (ALUControl == OP_MUL) begin
            w_mul_start  = 1'b1;
            w_state_next = ST_MUL;
          end else begin
            w_load_alu       = 1'b1;
            w_out_valid_next = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (w_mul_done) begin
          w_load_mul       = 1'b1;
          w_out_valid_next = 1'b1;
          w_state_next     = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register plus result/flag registers, which hold while not loading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= FLAGS_RESET;
    end else begin
      r_state     <= w_state_next;
      r_out_valid <= w_out_valid_next;
      if (w_load_alu) begin
        r_result <= w_alu_res;
        r_flags  <= make_flags(w_alu_res, w_alu_c, w_alu_v);
      end else if (w_load_mul) begin
        r_result <= w_mul_product;
        r_flags  <= make_flags(w_mul_product, 1'b0, 1'b0);
      end
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_mul_start),
    .op_a    (SrcA),
    .op_b    (SrcB),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  assign InReady   = w_in_ready;
  assign OutValid  = r_out_valid;
  assign ALUResult = r_result;
  assign ZF        = r_flags[FLAG_Z];
  assign SF        = r_flags[FLAG_S];
  assign CF        = r_flags[FLAG_C];
  assign VF        = r_flags[FLAG_V];
  assign Busy      = (r_state == ST_MUL);

endmodule
